// File: rtl/hdlc_rx_reader_if.sv
// Hdlc register port plus downstream byte stream between the rx reader and its neighbours.
// master = reader side, slave = Hdlc/consumer side.
interface hdlc_rx_reader_if;
   logic       Rx_Ready;
   logic [2:0] Address;
   logic       WriteEnable;
   logic       ReadEnable;
   logic [7:0] DataIn;
   logic [7:0] DataOut;
   logic [7:0] M_Data;
   logic       M_Valid;
   logic       M_Ready;
   logic       M_Last;

   modport master (
      input  Rx_Ready, DataOut, M_Ready,
      output Address, WriteEnable, ReadEnable, DataIn, M_Data, M_Valid, M_Last
   );

   modport slave (
      output Rx_Ready, DataOut, M_Ready,
      input  Address, WriteEnable, ReadEnable, DataIn, M_Data, M_Valid, M_Last
   );
endinterface

// File: rtl/hdlc_rx_reader.sv
// Drains received Hdlc frames over the 8-bit register port and streams the bytes out.
// Errored, empty or oversize frames are discarded through the Rx_Drop control bit.
module hdlc_rx_reader #(
   parameter int unsigned MAX_LEN = 128
) (
   input  logic                     Clk,
   input  logic                     Rst,
   hdlc_rx_reader_if.master         bus,
   output logic                     Frame_Done,
   output logic                     Frame_Drop,
   output logic                     Busy
);

   localparam int unsigned AW = 3;
   localparam int unsigned DW = 8;
   localparam logic [AW-1:0] ADDR_SC  = AW'(2);
   localparam logic [AW-1:0] ADDR_BUF = AW'(3);
   localparam logic [AW-1:0] ADDR_LEN = AW'(4);
   localparam logic [DW-1:0] RX_DROP  = DW'(8'h02);

   typedef enum logic [3:0] {
      IDLE, RD_SC, WAIT_SC, RD_LEN, WAIT_LEN, RD_BUF, WAIT_BUF, PUSH, DROP, DONE, SETTLE
   } state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] len_q, len_d;
   logic [DW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] addr_d;
   logic [DW-1:0] din_d, mdata_d;
   logic          re_d, we_d, mvalid_d, mlast_d, done_d, drop_d, busy_d;
   logic          last_c;

   // Next state, then the registered outputs decoded from that next state.
   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      mdata_d  = bus.M_Data;
      addr_d   = bus.Address;
      din_d    = bus.DataIn;
      re_d     = 1'b0;
      we_d     = 1'b0;
      mvalid_d = 1'b0;
      mlast_d  = 1'b0;
      done_d   = 1'b0;
      drop_d   = 1'b0;
      last_c   = (cnt_q == DW'(len_q - DW'(1)));

      case (state_q)
         IDLE:     if (bus.Rx_Ready) state_d = RD_SC;
         RD_SC:    state_d = WAIT_SC;
         WAIT_SC: begin
            if (|bus.DataOut[4:2])    state_d = DROP;
            else if (!bus.DataOut[0]) state_d = IDLE;
            else                      state_d = RD_LEN;
         end
         RD_LEN:   state_d = WAIT_LEN;
         WAIT_LEN: begin
            len_d = bus.DataOut;
            if (bus.DataOut == DW'(0) || 32'(bus.DataOut) > MAX_LEN) begin
               state_d = DROP;
            end else begin
               cnt_d   = DW'(0);
               state_d = RD_BUF;
            end
         end
         RD_BUF:   state_d = WAIT_BUF;
         WAIT_BUF: begin
            mdata_d = bus.DataOut;
            state_d = PUSH;
         end
         PUSH: begin
            if (bus.M_Ready) begin
               cnt_d   = DW'(cnt_q + DW'(1));
               state_d = last_c ? DONE : RD_BUF;
            end
         end
         DROP:     state_d = SETTLE;
         DONE:     state_d = SETTLE;
         SETTLE:   if (!bus.Rx_Ready) state_d = IDLE;
         default:  state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);

      case (state_d)
         RD_SC: begin
            re_d   = 1'b1;
            addr_d = ADDR_SC;
         end
         RD_LEN: begin
            re_d   = 1'b1;
            addr_d = ADDR_LEN;
         end
         RD_BUF: begin
            re_d   = 1'b1;
            addr_d = ADDR_BUF;
         end
         PUSH: begin
            mvalid_d = 1'b1;
            mlast_d  = (cnt_d == DW'(len_d - DW'(1)));
         end
         DROP: begin
            we_d   = 1'b1;
            addr_d = ADDR_SC;
            din_d  = RX_DROP;
            drop_d = 1'b1;
         end
         DONE:    done_d = 1'b1;
         default: ;
      endcase
   end

   // State and output registers; reset abandons any frame without issuing Rx_Drop.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state_q         <= IDLE;
         len_q           <= '0;
         cnt_q           <= '0;
         bus.Address     <= '0;
         bus.WriteEnable <= 1'b0;
         bus.ReadEnable  <= 1'b0;
         bus.DataIn      <= '0;
         bus.M_Data      <= '0;
         bus.M_Valid     <= 1'b0;
         bus.M_Last      <= 1'b0;
         Frame_Done      <= 1'b0;
         Frame_Drop      <= 1'b0;
         Busy            <= 1'b0;
      end else begin
         state_q         <= state_d;
         len_q           <= len_d;
         cnt_q           <= cnt_d;
         bus.Address     <= addr_d;
         bus.WriteEnable <= we_d;
         bus.ReadEnable  <= re_d;
         bus.DataIn      <= din_d;
         bus.M_Data      <= mdata_d;
         bus.M_Valid     <= mvalid_d;
         bus.M_Last      <= mlast_d;
         Frame_Done      <= done_d;
         Frame_Drop      <= drop_d;
         Busy            <= busy_d;
      end
   end

endmodule
